// File: rtl/puf_pkg.sv
// ============================================================================
// Module : puf_pkg
// Brief  : Shared types, constants and LFSR step function for the PUF sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package puf_pkg;

  localparam int CHALL_W = 8;

  localparam logic [CHALL_W-1:0] LFSR_POLY     = 8'hB8;
  localparam logic [CHALL_W-1:0] SEED_ZERO_SUB = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ARM   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

  // Galois right-shift step; feedback taps folded in when the LSB falls out.
  function automatic logic [CHALL_W-1:0] lfsr_next(input logic [CHALL_W-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : {CHALL_W{1'b0}});
  endfunction

endpackage

`default_nettype wire

// File: rtl/chall_lfsr.sv
// ============================================================================
// Module : chall_lfsr
// Brief  : 8-bit Galois LFSR producing the challenge stream; all-zero seed lock-up
//          is avoided by substituting a fixed non-zero seed.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module chall_lfsr
  import puf_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [CHALL_W-1:0] seed,
  input  logic               step,
  output logic [CHALL_W-1:0] value
);

  logic [CHALL_W-1:0] r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= '0;
    end else if (load) begin
      r_state <= (seed == '0) ? SEED_ZERO_SUB : seed;
    end else if (step) begin
      r_state <= lfsr_next(r_state);
    end
  end

  assign value = r_state;

endmodule

`default_nettype wire

// File: rtl/puf_seq.sv
// ============================================================================
// Module : puf_seq
// Brief  : Challenge sequencer / response collector driving one puf_bit cell.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module puf_seq
  import puf_pkg::*;
#(
  parameter int N_BITS      = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CHALL_W-1:0] seed,
  input  logic               bit_resp,
  input  logic               bit_finish,
  output logic [CHALL_W-1:0] chall,
  output logic               bit_en,
  output logic               bit_rst,
  output logic [N_BITS-1:0]  resp_word,
  output logic               valid,
  output logic               busy,
  output logic               timeout_err
);

  localparam int IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(N_BITS - 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  seq_state_t        r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [N_BITS-1:0] r_resp;
  logic              r_bit_en, r_bit_rst, r_valid, r_busy, r_tmo;
  logic              w_bit_en_nxt, w_bit_rst_nxt, w_valid_nxt, w_busy_nxt;
  logic              w_accept, w_capture, w_last, w_expire, w_step;

  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_accept  = (r_state == ST_IDLE) && start;
  assign w_last    = (r_idx == C_IDX_LAST);
  assign w_capture = (r_state == ST_WAIT) && bit_finish;
  // A finish in the final counted cycle still wins over the abort.
  assign w_expire  = (r_state == ST_WAIT) && !bit_finish && (w_cnt_inc == C_CNT_LAST);
  assign w_step    = w_capture && !w_last;

  chall_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (w_accept),
    .seed  (seed),
    .step  (w_step),
    .value (chall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_CLEAR;
      ST_CLEAR: w_state_nxt = ST_ARM;
      ST_ARM:   w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (bit_finish) begin
          w_state_nxt = w_last ? ST_DONE : ST_CLEAR;
        end else if (w_expire) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    w_bit_en_nxt  = (w_state_nxt == ST_ARM) || (w_state_nxt == ST_WAIT);
    w_bit_rst_nxt = !w_bit_en_nxt;
    w_valid_nxt   = (w_state_nxt == ST_DONE);
    w_busy_nxt    = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_en  <= 1'b0;
      r_bit_rst <= 1'b1;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_tmo     <= 1'b0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_resp    <= '0;
    end else begin
      r_bit_en  <= w_bit_en_nxt;
      r_bit_rst <= w_bit_rst_nxt;
      r_valid   <= w_valid_nxt;
      r_busy    <= w_busy_nxt;

      if (w_accept) begin
        r_idx  <= '0;
        r_resp <= '0;
        r_tmo  <= 1'b0;
      end else if (w_capture) begin
        for (int i = 0; i < N_BITS; i++) begin
          if (r_idx == IDX_W'(i)) r_resp[i] <= bit_resp;
        end
        if (!w_last) r_idx <= r_idx + IDX_W'(1);
      end else if (w_expire) begin
        r_tmo <= 1'b1;
      end

      if (r_state == ST_ARM) begin
        r_cnt <= '0;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

  assign bit_en      = r_bit_en;
  assign bit_rst     = r_bit_rst;
  assign valid       = r_valid;
  assign busy        = r_busy;
  assign timeout_err = r_tmo;
  assign resp_word   = r_resp;

endmodule

`default_nettype wire

// File: tb/tb_puf_seq.sv
// ============================================================================
// Module : tb_puf_seq
// Brief  : Directed, table-driven bench for puf_seq (N_BITS=8, TIMEOUT_CYC=16).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_puf_seq;

  localparam int NB = 8;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] seed = 8'h00;
  logic       bit_resp = 1'b0;
  logic       bit_finish = 1'b0;
  logic [7:0] chall;
  logic       bit_en, bit_rst, valid, busy, timeout_err;
  logic [7:0] resp_word;

  int total = 0;
  int bad   = 0;

  puf_seq #(.N_BITS(NB), .TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .seed        (seed),
    .bit_resp    (bit_resp),
    .bit_finish  (bit_finish),
    .chall       (chall),
    .bit_en      (bit_en),
    .bit_rst     (bit_rst),
    .resp_word   (resp_word),
    .valid       (valid),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [7:0]  sd;
    logic        fin;
    logic        rsp;
    logic [20:0] exp;
  } vec_t;

  vec_t       tv [27];
  logic [7:0] ch [8] = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3, 8'hE1, 8'hC8};

  // Packed view: {chall, bit_en, bit_rst, valid, busy, resp_word, timeout_err}
  function automatic logic [20:0] pk(input logic [7:0] c, input logic en, input logic rs,
                                     input logic v, input logic b, input logic [7:0] w,
                                     input logic t);
    return {c, en, rs, v, b, w, t};
  endfunction

  function automatic logic [20:0] snap();
    return {chall, bit_en, bit_rst, valid, busy, resp_word, timeout_err};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h  (fields chall|en|rst|valid|busy|word|tmo)", nm, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; bit_finish = 1'b0; bit_resp = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic run_word(input logic [7:0] sd, input string nm);
    logic [7:0] part;
    for (int c = 0; c < 27; c++) tv[c] = '{1'b0, sd, 1'b0, 1'b0, 21'h0};
    tv[0].st  = 1'b1;
    tv[0].exp = pk(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      part = 8'h55 & 8'((1 << i) - 1);
      tv[1+3*i].exp = pk(ch[i], 1'b0, 1'b1, 1'b0, 1'b1, part, 1'b0);
      tv[2+3*i].exp = pk(ch[i], 1'b1, 1'b0, 1'b0, 1'b1, part, 1'b0);
      tv[3+3*i].exp = pk(ch[i], 1'b1, 1'b0, 1'b0, 1'b1, part, 1'b0);
      tv[3+3*i].fin = 1'b1;
      tv[3+3*i].rsp = (i % 2 == 0);
    end
    tv[25].st  = 1'b1;
    tv[25].sd  = 8'h77;
    tv[25].exp = pk(8'hC8, 1'b0, 1'b1, 1'b1, 1'b1, 8'h55, 1'b0);
    tv[26].exp = pk(8'hC8, 1'b0, 1'b1, 1'b0, 1'b0, 8'h55, 1'b0);
    for (int c = 0; c < 27; c++) begin
      chk($sformatf("%s_c%0d", nm, c), 32'(snap()), 32'(tv[c].exp));
      start      = tv[c].st;
      seed       = tv[c].sd;
      bit_finish = tv[c].fin;
      bit_resp   = tv[c].rsp;
      cyc();
    end
    start = 1'b0; bit_finish = 1'b0; bit_resp = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nval;
    @(negedge clk);
    cyc();
    chk("reset", 32'(snap()), 32'(pk(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0)));

    rst = 1'b0;
    cyc();
    run_word(8'h01, "nominal");

    do_reset();
    run_word(8'h00, "zeroseed");

    // Timeout: ARM at cycle 2, abort visible at cycle 18.
    do_reset();
    start = 1'b1; seed = 8'h01;
    cyc();
    start = 1'b0;
    nval = 0;
    for (int c = 1; c < 18; c++) begin
      if (valid) nval++;
      if (c == 17) chk("to_before", 32'({busy, timeout_err}), 32'(2'b10));
      cyc();
    end
    chk("to_abort", 32'(snap()), 32'(pk(8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1)));
    for (int c = 0; c < 4; c++) begin
      if (valid) nval++;
      cyc();
    end
    chk("to_novalid", 32'(nval), 32'd0);
    chk("to_sticky", 32'(timeout_err), 32'd1);
    start = 1'b1; seed = 8'h01;
    cyc();
    start = 1'b0;
    chk("to_restart", 32'(snap()), 32'(pk(8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0)));

    // Collision: finish lands on the last counted WAIT cycle (cycle 17).
    do_reset();
    start = 1'b1; seed = 8'h01;
    cyc();
    start = 1'b0;
    for (int c = 1; c < 17; c++) cyc();
    chk("col_wait", 32'(snap()), 32'(pk(8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0)));
    bit_finish = 1'b1; bit_resp = 1'b1;
    cyc();
    bit_finish = 1'b0; bit_resp = 1'b0;
    chk("col_capture", 32'(snap()), 32'(pk(8'hB8, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0)));

    // Stale finish, ignored start in WAIT, then reset during bit 3.
    do_reset();
    start = 1'b1; seed = 8'h01;
    cyc();
    start = 1'b0; bit_finish = 1'b1; bit_resp = 1'b1;
    cyc();
    cyc();
    bit_finish = 1'b0;
    chk("stale_w0", 32'(snap()), 32'(pk(8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0)));
    cyc(); cyc(); cyc();
    chk("stale_w3", 32'(snap()), 32'(pk(8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0)));
    bit_finish = 1'b1; bit_resp = 1'b1;
    cyc();
    bit_finish = 1'b0; bit_resp = 1'b0;
    chk("stale_next", 32'(snap()), 32'(pk(8'hB8, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0)));
    cyc(); cyc();
    chk("ign_wait", 32'(snap()), 32'(pk(8'hB8, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0)));
    start = 1'b1; seed = 8'h33;
    cyc();
    start = 1'b0;
    chk("ign_hold", 32'(snap()), 32'(pk(8'hB8, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0)));
    bit_finish = 1'b1; bit_resp = 1'b0;
    cyc();
    bit_finish = 1'b0;
    chk("ign_clear", 32'(snap()), 32'(pk(8'h5C, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0)));
    cyc(); cyc();
    bit_finish = 1'b1; bit_resp = 1'b1;
    cyc();
    bit_finish = 1'b0; bit_resp = 1'b0;
    chk("b3_clear", 32'(snap()), 32'(pk(8'h2E, 1'b0, 1'b1, 1'b0, 1'b1, 8'h05, 1'b0)));
    cyc();
    chk("b3_arm", 32'(snap()), 32'(pk(8'h2E, 1'b1, 1'b0, 1'b0, 1'b1, 8'h05, 1'b0)));
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_rst", 32'(snap()), 32'(pk(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
